// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one memory port between an
// instruction fetch requester and a data load/store requester. Each access
// runs IDLE -> BUSY -> RESP -> IDLE. A BUSY phase that waits too long for
// mem_ack is aborted with zero read data and a bus_err pulse.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        instr_req,
    input  logic [31:0] pc_out,
    output logic        instr_valid,
    output logic [31:0] instr_read,
    input  logic        data_req,
    input  logic        data_write_enable,
    input  logic [31:0] data_adr,
    input  logic [31:0] data_write,
    output logic        data_valid,
    output logic [31:0] data_read,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_e;

    // Counter value seen during the last BUSY cycle allowed before the abort.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        last_data_q, last_data_d;   // 1: data side won the last grant
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_adr_q, mem_adr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        ivalid_q, ivalid_d;
    logic        dvalid_q, dvalid_d;
    logic        berr_q, berr_d;
    logic [31:0] iread_q, iread_d;
    logic [31:0] dread_q, dread_d;
    logic        grant_i, grant_d;

    // State and output registers; reset aborts any access immediately.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q     <= IDLE;
            last_data_q <= 1'b1;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
            ivalid_q    <= 1'b0;
            dvalid_q    <= 1'b0;
            berr_q      <= 1'b0;
            iread_q     <= '0;
            dread_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            ivalid_q    <= ivalid_d;
            dvalid_q    <= dvalid_d;
            berr_q      <= berr_d;
            iread_q     <= iread_d;
            dread_q     <= dread_d;
        end
    end

    // Arbitration: a lone requester wins; on contention the side that did
    // not win last time is granted.
    assign grant_i = instr_req && (!data_req || last_data_q);
    assign grant_d = data_req && (!instr_req || !last_data_q);

    // Next-state and next-output logic; pulses default low, bus fields hold.
    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;
        ivalid_d    = 1'b0;
        dvalid_d    = 1'b0;
        berr_d      = 1'b0;
        iread_d     = iread_q;
        dread_d     = dread_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d     = BUSY_I;
                    last_data_d = 1'b0;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_adr_d   = pc_out;
                    mem_wdata_d = '0;
                end else if (grant_d) begin
                    state_d     = BUSY_D;
                    last_data_d = 1'b1;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = data_write_enable;
                    mem_adr_d   = data_adr;
                    mem_wdata_d = data_write;
                end
            end
            BUSY_I, BUSY_D: begin
                // An ack in the final allowed cycle still counts as success.
                if (mem_ack || cnt_q == TO_LAST) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    berr_d    = !mem_ack;
                    if (state_q == BUSY_I) begin
                        state_d  = RESP_I;
                        ivalid_d = 1'b1;
                        iread_d  = mem_ack ? mem_rdata : 32'h0;
                    end else begin
                        state_d  = RESP_D;
                        dvalid_d = 1'b1;
                        dread_d  = mem_ack ? mem_rdata : 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP_I, RESP_D: state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    assign instr_valid = ivalid_q;
    assign instr_read  = iread_q;
    assign data_valid  = dvalid_q;
    assign data_read   = dread_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_adr     = mem_adr_q;
    assign mem_wdata   = mem_wdata_q;
    assign bus_err     = berr_q;

endmodule
